// File: rtl/movimento_pkg.sv
// Shared types and helpers for the movement button sequencer (controle_movimento).
package movimento_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    REPETE
  } estado_t;

  // Bit positions inside the {N,S,L,O} button vector
  localparam int DIR_N   = 3;
  localparam int DIR_S   = 2;
  localparam int DIR_L   = 1;
  localparam int DIR_O   = 0;
  localparam int NUM_DIR = 4;

  // True when exactly one direction is pressed
  function automatic logic um_quente(input logic [NUM_DIR-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/filtro_botao.sv
// One button bit: 2-flop synchronizer followed by a debounce filter that is
// present only when CONTROLE_MOVIMENTO_DEBOUNCE_EN is defined.
module filtro_botao
`ifdef CONTROLE_MOVIMENTO_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CICLOS = 1000000
)
`endif
(
  input  logic clk_50,
  input  logic reset_n,
  input  logic bruto,
  output logic filtrado
);

  logic sync_a;
  logic sync_b;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      // NOTE: non-blocking, so sync_b takes the previous sync_a; blocking would merge the two stages.
      sync_a <= bruto;
      sync_b <= sync_a;
    end
  end

`ifdef CONTROLE_MOVIMENTO_DEBOUNCE_EN
  localparam int CONT_W = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CONT_W-1:0] LIMITE = CONT_W'(DEBOUNCE_CICLOS - 1);

  logic [CONT_W-1:0] cont;

  // Count consecutive cycles of disagreement; any agreement restarts the count
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      cont     <= '0;
      filtrado <= 1'b0;
    end else if (sync_b == filtrado) begin
      cont <= '0;
    end else if (cont == LIMITE) begin
      filtrado <= sync_b;
      cont     <= '0;
    end else begin
      cont <= cont + 1'b1;
    end
  end
`else
  assign filtrado = sync_b;
`endif

endmodule

// File: rtl/controle_movimento.sv
// Button-to-step sequencer: filtered direction buttons become single-cycle steps
// with auto-repeat. Debounce filter enabled by CONTROLE_MOVIMENTO_DEBOUNCE_EN.
module controle_movimento #(
  parameter int DEBOUNCE_CICLOS   = 1000000,
  parameter int ATRASO_REPETICAO  = 25000000,
  parameter int PERIODO_REPETICAO = 5000000
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic [3:0]  botoes,
  input  logic        habilita,
  output logic        passo_N,
  output logic        passo_S,
  output logic        passo_L,
  output logic        passo_O,
  output logic        ocupado,
  output logic [15:0] contador_passos
);

  import movimento_pkg::*;

  if (DEBOUNCE_CICLOS < 1 || ATRASO_REPETICAO < 1 || PERIODO_REPETICAO < 1) begin : g_parametro_invalido
    $error("controle_movimento: all cycle parameters must be >= 1");
  end

  localparam int MAIOR   = (ATRASO_REPETICAO > PERIODO_REPETICAO) ? ATRASO_REPETICAO : PERIODO_REPETICAO;
  localparam int TIMER_W = $clog2(MAIOR) + 1;
  localparam logic [TIMER_W-1:0] CARGA_ATRASO  = TIMER_W'(ATRASO_REPETICAO - 1);
  localparam logic [TIMER_W-1:0] CARGA_PERIODO = TIMER_W'(PERIODO_REPETICAO - 1);

  logic [NUM_DIR-1:0] filtrado;
  logic               dir_valida;
  estado_t            estado;
  logic [NUM_DIR-1:0] dir;
  logic [NUM_DIR-1:0] passo;
  logic [TIMER_W-1:0] timer;

  for (genvar i = 0; i < NUM_DIR; i++) begin : g_filtro
    filtro_botao
`ifdef CONTROLE_MOVIMENTO_DEBOUNCE_EN
      #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS))
`endif
      u_filtro (
        .clk_50   (clk_50),
        .reset_n  (reset_n),
        .bruto    (botoes[i]),
        .filtrado (filtrado[i])
      );
  end

  // Opposing or multiple presses are treated exactly like no press
  assign dir_valida = um_quente(filtrado);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      estado          <= OCIOSO;
      dir             <= '0;
      timer           <= '0;
      passo           <= '0;
      ocupado         <= 1'b0;
      contador_passos <= '0;
    end else begin
      passo <= '0;
      unique case (estado)
        OCIOSO: begin
          if (habilita && dir_valida) begin
            passo           <= filtrado;
            dir             <= filtrado;
            contador_passos <= contador_passos + 16'd1;
            timer           <= CARGA_ATRASO;
            ocupado         <= 1'b1;
            estado          <= ESPERA;
          end
        end
        ESPERA, REPETE: begin
          // A direction change must go through OCIOSO so the new press restarts the delay
          if (!habilita || !dir_valida || filtrado != dir) begin
            ocupado <= 1'b0;
            estado  <= OCIOSO;
          end else if (timer == '0) begin
            passo           <= dir;
            contador_passos <= contador_passos + 16'd1;
            timer           <= CARGA_PERIODO;
            estado          <= REPETE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
      endcase
    end
  end

  assign passo_N = passo[DIR_N];
  assign passo_S = passo[DIR_S];
  assign passo_L = passo[DIR_L];
  assign passo_O = passo[DIR_O];

endmodule

// File: doc/controle_movimento.md
Name: controle_movimento

Overview:
- Sequencer that turns raw, bouncy direction buttons into clean single-cycle step commands N, S, L, O for the player-position datapath (movimentacao).
- Stages: synchronizes, filters, rejects conflicting presses, issues one step on press, then auto-repeats while held (delay, then fixed rate).
- Sits between the board push-buttons and the movimentacao N/S/L/O inputs; gated by game-enable.

Parameters:
- DEBOUNCE_CICLOS, 1000000, cycles a synchronized button level must be stable before it is accepted (20 ms at 50 MHz).
- ATRASO_REPETICAO, 25000000, cycles from the first step to the first repeat step (500 ms).
- PERIODO_REPETICAO, 5000000, cycles between consecutive repeat steps (100 ms).

Ports:
- clk_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- botoes  in  4  raw buttons {N,S,L,O}, active-high, asynchronous to clk_50
- habilita  in  1  game active; when low no steps are issued
- passo_N  out  1  one-cycle step north, to movimentacao N
- passo_S  out  1  one-cycle step south, to movimentacao S
- passo_L  out  1  one-cycle step east, to movimentacao L
- passo_O  out  1  one-cycle step west, to movimentacao O
- ocupado  out  1  high while in ESPERA or REPETE (button held and being tracked)
- contador_passos  out  16  total steps issued since reset; wraps 65535->0

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, synchronizer/filter registers 0, FSM in OCIOSO, counters 0. Reset release mid-press: no step is issued until the press passes the full synchronizer and filter path.
- Input path, per bit: 2-flop synchronizer, then filter. The filtered bit changes only after the synchronized value has differed from it for DEBOUNCE_CICLOS consecutive cycles. Any glitch restarts the count.
- Direction decode: dir_valida = filtered vector has exactly one bit set. Zero bits or 2+ bits (including opposing N+S) count as "no press".
- FSM (registered), states OCIOSO, ESPERA, REPETE:
  - OCIOSO: if habilita && dir_valida, pulse the matching passo_* next cycle, latch dir, load timer = ATRASO_REPETICAO-1, go to ESPERA.
  - ESPERA: if !habilita, or !dir_valida, or dir != latched, go to OCIOSO with no pulse. Else if timer == 0, pulse, load timer = PERIODO_REPETICAO-1, go to REPETE. Else decrement timer.
  - REPETE: same release check as ESPERA. Else if timer == 0, pulse and reload PERIODO_REPETICAO-1. Else decrement timer.
- Direction change while held: the path passes through OCIOSO, so the new direction steps 2 cycles after the filtered change (1 cycle to leave, 1 to issue).
- Latency: filtered press to passo_* high = 1 cycle. Raw stable press to passo_* = 2 (sync) + DEBOUNCE_CICLOS + 1 cycles.
- Output rules: passo_* are registered, at most one high per cycle, exactly 1 cycle wide. contador_passos increments in the same cycle as each pulse.
- Timer width is $clog2 of max(ATRASO_REPETICAO, PERIODO_REPETICAO) + 1. Parameters must be >= 1; a value of 1 means a repeat every cycle.
- habilita falling in any state: go to OCIOSO next cycle with no pulse. Buttons held when habilita rises produce an immediate first step.

Optional Feature:
- CONTROLE_MOVIMENTO_DEBOUNCE_EN
  - Defined: filter as above.
  - Undefined: filter removed. The filtered bit equals the synchronized bit, so raw-to-step latency is 3 cycles. DEBOUNCE_CICLOS is ignored.
  - Simulation benches run both builds.

Decomposition:
- Package movimento_pkg holds:
  - the state enum {OCIOSO, ESPERA, REPETE};
  - direction index constants DIR_N=3, DIR_S=2, DIR_L=1, DIR_O=0;
  - the helper function for the one-hot-valid check.
- Sub-module filtro_botao (1-bit synchronizer plus optional debounce), instantiated 4 times. The FSM and timers stay in the top module.

Test Plan (DEBOUNCE_CICLOS=4, ATRASO_REPETICAO=10, PERIODO_REPETICAO=3, debounce enabled unless noted):
- Reset asserted mid-hold with botoes=4'b1000 -> all outputs 0 immediately, contador_passos=0; after release with the button still held, first passo_N occurs exactly 2+4+1=7 cycles after reset_n rises.
- botoes=4'b0010 held 30 cycles after acceptance -> passo_L pulses at t=0, 10, 13, 16, 19, 22, 25, 28; contador_passos=8; no other passo_* ever high.
- Bounce: botoes toggles 0/1 every 2 cycles for 20 cycles, then settles at 0 -> no pulse, contador_passos unchanged.
- botoes=4'b1100 (N+S) or 4'b1010 held -> no pulses, ocupado=0. Then change to 4'b0100 -> single passo_S after filtering.
- Hold 4'b0001 into REPETE, then switch to 4'b1000 -> passo_O stops; passo_N fires 2 cycles after the filtered change; repeat timing restarts from ATRASO_REPETICAO.
- habilita=0 while holding 4'b0010 -> no pulses, ocupado=0. habilita 0->1 -> passo_L the next cycle. Debounce disabled build: raw press to passo_L = 3 cycles.
